// File: rtl/arm_cond_pkg.sv
// ARM condition-code constants, NZCV bit positions and the writeback entry type
// shared by the commit stage and the condition checker.
package arm_cond_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;

    typedef logic [3:0] nzcv_t;

    typedef struct packed {
        logic [31:0] dat;
        logic [3:0]  rd;
    } wb_entry_t;

endpackage

// File: rtl/alu_result_commit_if.sv
// ALU-result and register-file writeback handshake bundle.
// slave = commit block, master = ALU / register-file side.
interface alu_result_commit_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic        in_negative;
    logic        in_zero;
    logic        in_carry;
    logic        in_overflow;
    logic [3:0]  in_cond;
    logic        in_set_flags;
    logic        in_write_rd;
    logic [3:0]  in_rd;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [3:0]  wb_rd;

    modport slave (
        input  in_valid, in_result, in_negative, in_zero, in_carry, in_overflow,
               in_cond, in_set_flags, in_write_rd, in_rd, wb_ready,
        output in_ready, wb_valid, wb_data, wb_rd
    );

    modport master (
        output in_valid, in_result, in_negative, in_zero, in_carry, in_overflow,
               in_cond, in_set_flags, in_write_rd, in_rd, wb_ready,
        input  in_ready, wb_valid, wb_data, wb_rd
    );
endinterface

// File: rtl/arm_cond_check.sv
// Combinational ARM condition evaluator: (cond, nzcv) -> pass. Zero latency, no handshake.
// Odd codes are the negation of the even code below them; AL/NV are the exception.
module arm_cond_check
    import arm_cond_pkg::*;
(
    input  logic [3:0] cond_i,
    input  nzcv_t      nzcv_i,
    output logic       pass_o
);
    logic n, z, c, v;
    logic base;

    assign n = nzcv_i[NZCV_N];
    assign z = nzcv_i[NZCV_Z];
    assign c = nzcv_i[NZCV_C];
    assign v = nzcv_i[NZCV_V];

    always_comb begin
        base = 1'b1;
        unique case (cond_i[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        pass_o = (cond_i[3:1] == 3'd7) ? ~cond_i[0] : (base ^ cond_i[0]);
    end
endmodule

// File: rtl/alu_result_commit.sv
// ALU result commit: NZCV register, condition check, 2-entry writeback FIFO; flags/writeback 1 cycle after accept.
// Backpressure: in_ready = FIFO not full (registered count only); holds while wb_ready low. ALU_COMMIT_PERF_EN adds perf counters.
module alu_result_commit
    import arm_cond_pkg::*;
#(
    parameter int WB_DEPTH = 2
)(
    input  logic                  clk,
    input  logic                  rst,
    alu_result_commit_if.slave    bus,
    input  logic                  flags_ld,
    input  logic [3:0]            flags_ld_nzcv,
    output nzcv_t                 flags_nzcv,
    output logic                  cond_fail
`ifdef ALU_COMMIT_PERF_EN
    ,
    output logic [15:0]           perf_retired,
    output logic [15:0]           perf_cond_fail
`endif
);
    nzcv_t     flags_q, flags_d;
    logic      cond_fail_q, cond_fail_d;
    wb_entry_t mem_q [2];
    wb_entry_t mem_d [2];
    logic      wr_ptr_q, wr_ptr_d;
    logic      rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;

    logic pass, acc, push, pop;

    arm_cond_check u_cond (
        .cond_i (bus.in_cond),
        .nzcv_i (flags_q),
        .pass_o (pass)
    );

    assign bus.in_ready = (count_q != 2'(WB_DEPTH));
    assign bus.wb_valid = (count_q != 2'd0);
    assign bus.wb_data  = mem_q[rd_ptr_q].dat;
    assign bus.wb_rd    = mem_q[rd_ptr_q].rd;
    assign flags_nzcv   = flags_q;
    assign cond_fail    = cond_fail_q;

    assign acc  = bus.in_valid & bus.in_ready;
    assign push = acc & pass & bus.in_write_rd;
    assign pop  = bus.wb_valid & bus.wb_ready;

    always_comb begin
        flags_d     = flags_q;
        cond_fail_d = acc & ~pass;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;

        // MSR load wins over a same-cycle S-bit update
        if (flags_ld) begin
            flags_d = flags_ld_nzcv;
        end else if (acc && pass && bus.in_set_flags) begin
            flags_d = {bus.in_negative, bus.in_zero, bus.in_carry, bus.in_overflow};
        end

        if (push) begin
            mem_d[wr_ptr_q] = '{dat: bus.in_result, rd: bus.in_rd};
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q     <= '0;
            cond_fail_q <= 1'b0;
            mem_q[0]    <= '0;
            mem_q[1]    <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= '0;
        end else begin
            flags_q     <= flags_d;
            cond_fail_q <= cond_fail_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

`ifdef ALU_COMMIT_PERF_EN
    logic [15:0] perf_ret_q, perf_ret_d;
    logic [15:0] perf_fail_q, perf_fail_d;

    always_comb begin
        perf_ret_d  = perf_ret_q;
        perf_fail_d = perf_fail_q;
        if (acc && pass && perf_ret_q != 16'hFFFF) begin
            perf_ret_d = perf_ret_q + 16'd1;
        end
        if (acc && !pass && perf_fail_q != 16'hFFFF) begin
            perf_fail_d = perf_fail_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_ret_q  <= '0;
            perf_fail_q <= '0;
        end else begin
            perf_ret_q  <= perf_ret_d;
            perf_fail_q <= perf_fail_d;
        end
    end

    assign perf_retired   = perf_ret_q;
    assign perf_cond_fail = perf_fail_q;
`endif

endmodule

// File: tb/tb_alu_result_commit.sv
// Randomized + directed bench for alu_result_commit against a queue-based reference model.
module tb_alu_result_commit;
    import arm_cond_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flags_ld;
    logic [3:0]  flags_ld_nzcv;
    nzcv_t       flags_nzcv;
    logic        cond_fail;
`ifdef ALU_COMMIT_PERF_EN
    logic [15:0] perf_retired, perf_cond_fail;
    int          m_ret, m_fail;
`endif

    alu_result_commit_if bus ();

    alu_result_commit #(.WB_DEPTH(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus.slave),
        .flags_ld      (flags_ld),
        .flags_ld_nzcv (flags_ld_nzcv),
        .flags_nzcv    (flags_nzcv),
        .cond_fail     (cond_fail)
`ifdef ALU_COMMIT_PERF_EN
        ,
        .perf_retired  (perf_retired),
        .perf_cond_fail(perf_cond_fail)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [35:0] m_q [$];
    logic [3:0]  m_flags;
    logic        m_cf;
    logic [31:0] drained [$];

    task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            COND_EQ: return z;
            COND_NE: return !z;
            COND_CS: return cy;
            COND_CC: return !cy;
            COND_MI: return n;
            COND_PL: return !n;
            COND_VS: return v;
            COND_VC: return !v;
            COND_HI: return cy && !z;
            COND_LS: return !cy || z;
            COND_GE: return n == v;
            COND_LT: return n != v;
            COND_GT: return !z && (n == v);
            COND_LE: return z || (n != v);
            COND_AL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic set_op(input logic vld, input logic [31:0] res, input logic [3:0] nzcv,
                          input logic [3:0] cond, input logic s, input logic w, input logic [3:0] rd);
        bus.in_valid     = vld;
        bus.in_result    = res;
        bus.in_negative  = nzcv[3];
        bus.in_zero      = nzcv[2];
        bus.in_carry     = nzcv[1];
        bus.in_overflow  = nzcv[0];
        bus.in_cond      = cond;
        bus.in_set_flags = s;
        bus.in_write_rd  = w;
        bus.in_rd        = rd;
    endtask

    task automatic model_clear();
        m_q.delete();
        m_flags = 4'b0000;
        m_cf    = 1'b0;
`ifdef ALU_COMMIT_PERF_EN
        m_ret  = 0;
        m_fail = 0;
`endif
    endtask

    task automatic check_outputs(input string where);
        chk({where, ".flags"}, 36'(flags_nzcv), 36'(m_flags));
        chk({where, ".wb_valid"}, 36'(bus.wb_valid), 36'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            chk({where, ".wb_entry"}, {bus.wb_data, bus.wb_rd}, m_q[0]);
        end
        chk({where, ".cond_fail"}, 36'(cond_fail), 36'(m_cf));
        chk({where, ".in_ready"}, 36'(bus.in_ready), 36'(m_q.size() < 2));
`ifdef ALU_COMMIT_PERF_EN
        chk({where, ".perf_ret"}, 36'(perf_retired), 36'(m_ret));
        chk({where, ".perf_fail"}, 36'(perf_cond_fail), 36'(m_fail));
`endif
    endtask

    // One clock: predict from pre-edge inputs, advance model at the edge, check 1 time unit later.
    task automatic step(output bit accepted);
        bit acc, pass, pop;
        if (bus.wb_valid && bus.wb_ready) drained.push_back(bus.wb_data);
        acc  = bus.in_valid && (m_q.size() < 2);
        pass = cond_holds(bus.in_cond, m_flags);
        pop  = (m_q.size() != 0) && bus.wb_ready;
        @(posedge clk);
        if (pop) void'(m_q.pop_front());
        if (acc && pass && bus.in_write_rd) m_q.push_back({bus.in_result, bus.in_rd});
        m_cf = acc && !pass;
        if (flags_ld) m_flags = flags_ld_nzcv;
        else if (acc && pass && bus.in_set_flags)
            m_flags = {bus.in_negative, bus.in_zero, bus.in_carry, bus.in_overflow};
`ifdef ALU_COMMIT_PERF_EN
        if (acc && pass && m_ret < 65535) m_ret++;
        if (acc && !pass && m_fail < 65535) m_fail++;
`endif
        accepted = acc;
        #1;
        check_outputs("step");
    endtask

    task automatic idle_steps(input int n);
        bit a;
        set_op(1'b0, 32'h0, 4'h0, COND_AL, 1'b0, 1'b0, 4'h0);
        for (int i = 0; i < n; i++) step(a);
    endtask

    initial begin
        bit a;
        rst = 1'b1;
        flags_ld = 1'b0;
        flags_ld_nzcv = 4'h0;
        bus.wb_ready = 1'b1;
        set_op(1'b0, 32'h0, 4'h0, COND_AL, 1'b0, 1'b0, 4'h0);
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        chk("reset.wb_data", 36'(bus.wb_data), 36'd0);
        chk("reset.wb_rd", 36'(bus.wb_rd), 36'd0);
        rst = 1'b0;
        idle_steps(1);

        // ADDS result 30, flags 0000, AL, rd=2
        set_op(1'b1, 32'd30, 4'b0000, COND_AL, 1'b1, 1'b1, 4'd2);
        step(a);
        chk("adds.flags", 36'(flags_nzcv), 36'b0000);
        chk("adds.wb_valid", 36'(bus.wb_valid), 36'd1);
        chk("adds.wb_data", 36'(bus.wb_data), 36'd30);
        chk("adds.wb_rd", 36'(bus.wb_rd), 36'd2);

        // CMP 10,20 then ADDLT
        set_op(1'b1, 32'hFFFF_FFF6, 4'b1000, COND_AL, 1'b1, 1'b0, 4'd0);
        step(a);
        chk("cmp.wb_valid", 36'(bus.wb_valid), 36'd0);
        chk("cmp.flags", 36'(flags_nzcv), 36'b1000);
        set_op(1'b1, 32'd5, 4'b0000, COND_LT, 1'b0, 1'b1, 4'd3);
        step(a);
        chk("addlt.wb_data", 36'(bus.wb_data), 36'd5);
        chk("addlt.wb_rd", 36'(bus.wb_rd), 36'd3);

        // Failing NE with Z set
        set_op(1'b1, 32'd0, 4'b0100, COND_AL, 1'b1, 1'b0, 4'd0);
        step(a);
        set_op(1'b1, 32'd99, 4'b1111, COND_NE, 1'b1, 1'b1, 4'd7);
        step(a);
        chk("ne.cond_fail", 36'(cond_fail), 36'd1);
        chk("ne.flags", 36'(flags_nzcv), 36'b0100);
        chk("ne.wb_valid", 36'(bus.wb_valid), 36'd0);
        idle_steps(1);
        chk("ne.cond_fail_clr", 36'(cond_fail), 36'd0);

        // Back-pressure: three writers with wb_ready low
        bus.wb_ready = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            set_op(1'b1, 32'(k), 4'b0000, COND_AL, 1'b0, 1'b1, 4'(k));
            step(a);
        end
        chk("bp.in_ready_full", 36'(bus.in_ready), 36'd0);
        set_op(1'b1, 32'd3, 4'b0000, COND_AL, 1'b0, 1'b1, 4'd3);
        step(a);
        chk("bp.third_held", 36'(a), 36'd0);
        drained.delete();
        bus.wb_ready = 1'b1;
        a = 1'b0;
        for (int t = 0; t < 8 && !a; t++) step(a);
        chk("bp.third_accepted", 36'(a), 36'd1);
        idle_steps(4);
        chk("bp.drain_count", 36'(drained.size()), 36'd3);
        for (int k = 0; k < 3; k++) begin
            if (k < drained.size()) chk("bp.drain_order", 36'(drained[k]), 36'(k + 1));
        end

        // Direct load collides with S-bit update
        flags_ld = 1'b1;
        flags_ld_nzcv = 4'b0011;
        set_op(1'b1, 32'd0, 4'b1000, COND_AL, 1'b1, 1'b0, 4'd0);
        step(a);
        flags_ld = 1'b0;
        chk("ld.flags", 36'(flags_nzcv), 36'b0011);
        idle_steps(1);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            set_op($urandom_range(0, 3) != 0, $urandom, 4'($urandom), 4'($urandom),
                   1'($urandom), $urandom_range(0, 3) != 0, 4'($urandom));
            bus.wb_ready  = $urandom_range(0, 9) < 6;
            flags_ld      = $urandom_range(0, 9) == 0;
            flags_ld_nzcv = 4'($urandom);
            step(a);
        end
        flags_ld = 1'b0;

        // Reset with two buffered entries
        bus.wb_ready = 1'b0;
        set_op(1'b1, 32'hAAAA, 4'b1010, COND_AL, 1'b1, 1'b1, 4'd9);
        for (int t = 0; t < 4; t++) step(a);
        chk("midrst.full", 36'(bus.in_ready), 36'd0);
        rst = 1'b1;
        #1;
        model_clear();
        chk("midrst.wb_valid", 36'(bus.wb_valid), 36'd0);
        chk("midrst.flags", 36'(flags_nzcv), 36'b0000);
        chk("midrst.in_ready", 36'(bus.in_ready), 36'd1);
        @(posedge clk);
        #1;
        check_outputs("midrst.hold");
        rst = 1'b0;
        bus.wb_ready = 1'b1;
        idle_steps(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/alu_result_commit.md
# alu_result_commit

Result-consuming end of the ALU interface. Accepts one ALU result per handshake with its N/Z/C/V outputs, ARM condition field, S bit and destination register, then:
- holds the architectural NZCV flag register;
- evaluates the ARM condition against that register;
- updates flags for S-bit operations;
- queues passing register writes into a 2-entry buffer that drains to the register-file write port.

It sits between the ALU and the register file / CPSR in the arm7tdmi datapath.

## Interface
- `WB_DEPTH`, default 2: writeback buffer entries. Only 2 is supported.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: ALU result valid.
- `in_ready` output 1: block can accept; equals buffer count < 2.
- `in_result` input 32: ALU result.
- `in_negative`, `in_zero`, `in_carry`, `in_overflow` input 1 each: ALU flag outputs.
- `in_cond` input 4: ARM condition field (EQ=0000 … AL=1110, NV=1111).
- `in_set_flags` input 1: S bit.
- `in_write_rd` input 1: operation writes Rd. It is 0 for CMP.
- `in_rd` input 4: destination register index.
- `flags_ld` input 1: direct NZCV load (MSR path).
- `flags_ld_nzcv` input 4: value for the direct load.
- `flags_nzcv` output 4: flag register {N,Z,C,V}.
- `wb_valid` output 1: buffer head valid.
- `wb_ready` input 1: register file accepts.
- `wb_data` output 32: head data.
- `wb_rd` output 4: head register index.
- `cond_fail` output 1: registered one-cycle pulse when an accepted op fails its condition.

## Operation
- **Accept.** An op is accepted when `in_valid && in_ready`. Each accepted op is evaluated exactly once.
- **Condition check.** The condition is computed from the current `flags_nzcv` register value.
  - Standard ARM table: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1.
  - NV always fails.
- **Pass with `in_set_flags`.** `flags_nzcv` is set to {`in_negative`, `in_zero`, `in_carry`, `in_overflow`} on the same edge.
- **Pass with `in_write_rd`.** {`in_result`, `in_rd`} is pushed to the buffer tail.
- **Fail.** No flag update, no push. `cond_fail` pulses on the next cycle.
- **Direct load.** If `flags_ld` is high, `flags_nzcv` takes `flags_ld_nzcv`. This overrides a same-cycle S-bit update.
  - A same-cycle accepted op still evaluates against the pre-load value.
- **Buffer.** 2-entry FIFO, in-order.
  - Pop occurs when `wb_valid && wb_ready`.
  - Push and pop in the same cycle keep the count unchanged.
  - Pop from empty is impossible, since `wb_valid` = count != 0.
- **Back-to-back ops.** Op k+1 evaluates against flags that already include op k's update, because the update is registered at op k's acceptance edge.
- **Stall rule.** `in_ready` depends only on the registered count. There is no combinational path from `wb_ready` to `in_ready`. An op that would not write still waits while the buffer is full.

## Timing
- **Reset values** (asynchronous, while `rst` is high): `flags_nzcv`=0000, count=0, `wb_valid`=0, `wb_data`=0, `wb_rd`=0, `cond_fail`=0, `in_ready`=1. Buffer contents are cleared.
- **Flag latency.** An accepted S-bit op is visible on `flags_nzcv` 1 cycle after acceptance.
- **Writeback latency.** An accepted writing op appears on `wb_valid`/`wb_data` 1 cycle after acceptance when the buffer was empty; otherwise behind older entries.
- **Throughput.** 1 op/cycle while `wb_ready` is held high.
- **Reset mid-operation.** Pending buffer entries are discarded. An in-flight handshake in the reset cycle is not accepted.
- **Output stability.** `wb_data`/`wb_rd` hold stable while `wb_valid && !wb_ready`.

## Configuration
- **`ALU_COMMIT_PERF_EN` defined:** adds outputs `perf_retired` (16-bit) and `perf_cond_fail` (16-bit).
  - `perf_retired` counts accepted condition-passing ops; `perf_cond_fail` counts failing ops.
  - Both saturate at 16'hFFFF and reset to 0.
- **Undefined:** the ports and counters are absent. All other behaviour is identical.

## Structure
- **Package `arm_cond_pkg`:**
  - 4-bit condition-code constants (`COND_EQ` … `COND_NV`);
  - NZCV bit indices (N=3, Z=2, C=1, V=0);
  - typedef `nzcv_t` (4-bit).
- **Sub-module `arm_cond_check`:** combinational (cond, nzcv) → pass.
  - Reused later by the decode stage.
- The FIFO stays inline.

## Test plan
- **Reset, then ADDS** with result 30, flags 0000, cond AL, S=1, rd=2 → next cycle `flags_nzcv`=0000, `wb_valid`=1, `wb_data`=30, `wb_rd`=2.
- **CMP pair.** CMP (S=1, write_rd=0) with flags N=1 (10−20), then ADD cond LT, result 5, rd=3.
  - Expect: no writeback for the CMP, `flags_nzcv`=1000, then `wb_data`=5, `wb_rd`=3.
- **Failing condition.** With `flags_nzcv`=0100, an op with cond NE, S=1, write_rd=1 → `cond_fail` pulses, flags stay 0100, no `wb_valid`.
- **Back-pressure.** Hold `wb_ready`=0 and issue 3 writing ops (data 1, 2, 3).
  - Expect: `in_ready` drops after 2 accepts; the third is held.
  - Release `wb_ready` → data drains 1, 2, 3 in order.
- **Load vs S-bit collision.** `flags_ld`=1 with `flags_ld_nzcv`=0011 in the same cycle as an accepted S-bit op with flags 1000 → `flags_nzcv`=0011.
- **Reset mid-run.** Assert `rst` with 2 buffered entries → `wb_valid`=0 immediately, count 0, `flags_nzcv`=0000.
  - If `ALU_COMMIT_PERF_EN` is defined, the perf counters also read 0.
